parallel_out_ctrl: RTL
======================

// Module: parallel_out_ctrl
// PURPOSE
//  Memory-mapped multi-channel parallel output controller for the single-cycle MIPS data bus.
//  Decodes a window of NUM_CH channel registers plus one status register at the top of the
//  data address space. Gates the data-memory write enable for addresses inside the window.
//  Drives each channel to an external device via a 4-phase req/ack handshake.
// PARAMETERS
//  ADDR_W     8      data-bus address width
//  DATA_W     8      channel/register data width; must be >= 2*NUM_CH
//  NUM_CH     4      number of output channels (1..DATA_W/2)
//  BASE_ADDR  8'hFB  address of channel 0; channel k at BASE_ADDR+k, status at BASE_ADDR+NUM_CH
// PORTS
//  clk       in   1              system clock, all state on rising edge
//  rst_n     in   1              asynchronous, active-low reset
//  addr      in   ADDR_W         data-bus address (ALU result)
//  wr_data   in   DATA_W         store data (rt register)
//  we        in   1              store strobe from control unit
//  mem_we    out  1              write enable to data memory = we & ~hit (combinational)
//  rd_hit    out  1              addr inside window; selects rd_data on load mux (combinational)
//  rd_data   out  DATA_W         readback of addressed channel register or status (combinational)
//  ch_data   out  NUM_CH*DATA_W  channel k data on bits [k*DATA_W +: DATA_W], registered
//  ch_req    out  NUM_CH         per-channel request, registered
//  ch_ack    in   NUM_CH         per-channel acknowledge, asynchronous to clk
// BEHAVIOUR
//  Reset (rst_n low, any time): ch_data=0, ch_req=0, overflow=0, ack synchronisers=0,
//   all channel FSMs -> IDLE. Any handshake in flight is abandoned; device must tolerate req drop.
//  Decode: hit = (addr >= BASE_ADDR) && (addr <= BASE_ADDR+NUM_CH), compared at ADDR_W bits,
//   no wrap (window must not cross 2^ADDR_W-1; elaboration check). Addresses outside -> mem_we=we.
//  ch_ack passes through a 2-flop synchroniser per channel (ack_s); ack edge seen 2 clk later.
//  Channel FSM (per channel k):
//   IDLE:     write hit to k -> ch_data[k]<=wr_data, ch_req[k]<=1, -> REQ.
//   REQ:      ack_s[k]==1 -> ch_req[k]<=0, -> RELEASE.
//   RELEASE:  ack_s[k]==0 -> IDLE.
//   busy[k] = (state != IDLE). req visible the cycle after the write edge.
//  Write to channel k while busy: data NOT latched, FSM unchanged, overflow[k]<=1 (sticky).
//  Status register: rd bits [NUM_CH-1:0]=busy, [2*NUM_CH-1:NUM_CH]=overflow, rest 0.
//   Write to status: overflow[k] cleared where wr_data[NUM_CH+k]==1 (write-1-to-clear);
//   busy bits read-only. Same-cycle overflow set and W1C on same bit: set wins.
//  Channel read returns current ch_data[k] (last accepted value) regardless of state.
//  we=0: no state change from bus; handshakes progress independently each cycle.
//  ack already high when entering REQ: req drops after synchroniser delay (2 clk).
//  All channels independent; simultaneous events on different channels have no interaction.
// TESTING
//  1 Reset: rst_n=0 mid-REQ on ch1 -> ch_req=0, ch_data=0, status reads 8'h00 immediately.
//  2 Write 8'hA5 to 8'hFB, we=1 -> mem_we=0, next cycle ch_data[7:0]=A5, ch_req[0]=1;
//    raise ack0 -> req0 low 2 clk later; drop ack0 -> status busy0=0 after 2 clk.
//  3 Write 8'h3C to ch2 (8'hFD) while busy -> ch_data[23:16] unchanged, status=8'h44;
//    write 8'h40 to status 8'hFF -> status=8'h04; write 8'h04 -> still 8'h04 (busy RO).
//  4 Write 8'h11 to 8'hFA and to 8'h7F -> mem_we=1, rd_hit=0, no channel/status change.
//  5 Writes to ch0..ch3 on consecutive cycles, acks staggered -> four independent
//    req/ack sequences, each ch_data holds its own value; read of 8'hFC returns ch1 data.
//  6 Overflow set on ch3 same cycle as W1C of bit7 -> overflow[3] remains 1.

Source files
------------

// File: rtl/parallel_out_ctrl.sv
// parallel_out_ctrl: memory-mapped NUM_CH-channel parallel output port for the MIPS data bus,
// each channel handed to an external device through a 4-phase req/ack handshake.
module parallel_out_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hFB
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     we,
    output logic                     mem_we,
    output logic                     rd_hit,
    output logic [DATA_W-1:0]        rd_data,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_ack
);
    localparam int LAST = int'(BASE_ADDR) + NUM_CH;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST);

    if (LAST > 2**ADDR_W - 1) begin : g_bad_window
        $error("parallel_out_ctrl: register window wraps past the top of the address space");
    end
    if (NUM_CH < 1 || 2*NUM_CH > DATA_W) begin : g_bad_width
        $error("parallel_out_ctrl: status register cannot hold busy and overflow bits");
    end

    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, RELEASE = 2'b10} state_t;

    logic [ADDR_W-1:0] off;
    logic              hit;
    logic              wr_st;
    logic [NUM_CH-1:0] wr_ch;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] ack_m;
    logic [NUM_CH-1:0] ack_s;
    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [DATA_W-1:0] data_q  [NUM_CH];

    assign off    = addr - BASE_ADDR;
    assign hit    = (addr >= BASE_ADDR) && (addr <= LAST_ADDR);
    assign rd_hit = hit;
    assign mem_we = we & ~hit;
    assign wr_st  = we && hit && (off == ADDR_W'(NUM_CH));

    always_comb begin
        for (int k = 0; k < NUM_CH; k++)
            wr_ch[k] = we && hit && (off == ADDR_W'(k));
    end

    // ch_ack comes from an unrelated clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_m <= '0;
            ack_s <= '0;
        end else begin
            ack_m <= ch_ack;
            ack_s <= ack_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= '{default: IDLE};
        else
            state_q <= state_d;
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++)
            state_d[k] = (state_q[k] == IDLE    &&  wr_ch[k]) ? REQ     :
                         (state_q[k] == REQ     &&  ack_s[k]) ? RELEASE :
                         (state_q[k] == RELEASE && !ack_s[k]) ? IDLE    : state_q[k];
    end

    // REQ encoding puts req directly on a state flop bit, so it is glitch-free
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            busy[k]   = state_q[k] != IDLE;
            ch_req[k] = state_q[k][0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '{default: '0};
        end else begin
            for (int k = 0; k < NUM_CH; k++)
                if (wr_ch[k] && state_q[k] == IDLE)
                    data_q[k] <= wr_data;
        end
    end

    // a new overflow beats a simultaneous write-1-to-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= '0;
        else
            ovf <= (ovf & ~(wr_st ? wr_data[NUM_CH +: NUM_CH] : '0)) | (wr_ch & busy);
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++)
            ch_data[k*DATA_W +: DATA_W] = data_q[k];
    end

    always_comb begin
        rd_data = '0;
        if (hit) begin
            rd_data = (off == ADDR_W'(NUM_CH)) ? DATA_W'({ovf, busy}) : '0;
            for (int k = 0; k < NUM_CH; k++)
                if (off == ADDR_W'(k))
                    rd_data = data_q[k];
        end
    end
endmodule
